// File: rtl/tilt_move_ctrl.sv
// Tilt-to-step controller: turns accelerometer tilt into periodic 1-cycle step pulses.
// Build macro TILT_BUTTON_OVERRIDE_EN lets held buttons override tilt-derived steps.
module tilt_move_ctrl #(
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned DEADZONE   = 16,
    parameter int unsigned MIN_PERIOD = 8,
    parameter int unsigned BTN_PERIOD = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] accel_x,
    input  logic [8:0] accel_y,
    input  logic [3:0] btn,
    input  logic       enable,
    output logic [3:0] movement,
    output logic [1:0] tilt_active
);
    localparam int unsigned AW = 9;
    localparam int unsigned CW = 8;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [AW-1:0] CENTRE = AW'(256);
    localparam logic [AW-1:0] DZ     = AW'(DEADZONE);
    localparam logic [CW-1:0] MIN_P  = CW'(MIN_PERIOD);

    typedef enum logic [1:0] {AX_IDLE, AX_POS, AX_NEG} axis_state_e;

    // Index 0 is the X axis, index 1 the Y axis.
    logic [1:0][AW-1:0] acc_s1, acc_s2;
    logic [PW-1:0]      presc_q;
    logic               ms_tick_c;
    axis_state_e        state_q [2];
    axis_state_e        state_d [2];
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]         pos_c, neg_c;
    logic [3:0]         tilt_move_c;
    logic [3:0]         move_c;
    logic               override_c;

    function automatic logic [AW-1:0] abs_dev(input logic [AW-1:0] a);
        return (a >= CENTRE) ? a - CENTRE : CENTRE - a;
    endfunction

    // Period shrinks with tilt, clamped at the fastest allowed rate.
    function automatic logic [CW-1:0] step_period(input logic [AW-1:0] d);
        logic [CW-1:0] dc;
        logic [CW-1:0] p;
        dc = d[AW-1] ? 8'hFF : d[CW-1:0];
        p  = 8'hFF - dc;
        return (p < MIN_P) ? MIN_P : p;
    endfunction

    function automatic axis_state_e target_state(input logic [AW-1:0] a);
        logic [AW-1:0] d;
        axis_state_e   s;
        d = abs_dev(a);
        if (d < DZ || d == '0) s = AX_IDLE;
        else if (a > CENTRE)   s = AX_POS;
        else                   s = AX_NEG;
        return s;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_s1 <= {CENTRE, CENTRE};
            acc_s2 <= {CENTRE, CENTRE};
        end else begin
            acc_s1 <= {accel_y, accel_x};
            acc_s2 <= acc_s1;
        end
    end

    assign ms_tick_c = (presc_q == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) presc_q <= '0;
        else        presc_q <= ms_tick_c ? '0 : presc_q + PW'(1);
    end

    // Per-axis state and step counter; any state change restarts the period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_c   = '0;
        neg_c   = '0;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = target_state(acc_s2[i]);
            if (!enable || override_c || state_d[i] == AX_IDLE || state_d[i] != state_q[i]) begin
                cnt_d[i] = '0;
            end else if (ms_tick_c) begin
                if (cnt_q[i] >= step_period(abs_dev(acc_s2[i])) - CW'(1)) begin
                    cnt_d[i] = '0;
                    pos_c[i] = (state_q[i] == AX_POS);
                    neg_c[i] = (state_q[i] == AX_NEG);
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign tilt_move_c = {pos_c[0], neg_c[0], pos_c[1], neg_c[1]};

`ifdef TILT_BUTTON_OVERRIDE_EN
    localparam int unsigned BW = (BTN_PERIOD > 1) ? $clog2(BTN_PERIOD) : 1;

    logic [3:0]         btn_s1, btn_s2;
    logic [3:0][BW-1:0] bcnt_q, bcnt_d;
    logic [3:0]         bmove_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            bcnt_q <= '0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
            bcnt_q <= bcnt_d;
        end
    end

    always_comb begin
        bcnt_d  = bcnt_q;
        bmove_c = '0;
        for (int j = 0; j < 4; j++) begin
            if (!btn_s2[j] || !enable) begin
                bcnt_d[j] = '0;
            end else if (ms_tick_c) begin
                if (bcnt_q[j] >= BW'(BTN_PERIOD - 1)) begin
                    bcnt_d[j]  = '0;
                    bmove_c[j] = 1'b1;
                end else begin
                    bcnt_d[j] = bcnt_q[j] + BW'(1);
                end
            end
        end
    end

    // Opposing buttons held together cancel so right+left / down+up never fire.
    assign override_c = |btn_s2;
    assign move_c     = override_c ? (bmove_c & ~{btn_s2[2], btn_s2[3], btn_s2[0], btn_s2[1]})
                                   : tilt_move_c;
`else
    logic unused_btn;
    assign unused_btn = ^btn;
    assign override_c = 1'b0;
    assign move_c     = tilt_move_c;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= '{AX_IDLE, AX_IDLE};
            cnt_q       <= '0;
            movement    <= '0;
            tilt_active <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            movement    <= move_c;
            tilt_active <= {state_d[1] != AX_IDLE, state_d[0] != AX_IDLE};
        end
    end

endmodule

// File: tb/tb_tilt_move_ctrl.sv
// Directed self-checking bench for tilt_move_ctrl with a 10-cycle ms tick.
module tb_tilt_move_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] accel_x;
    logic [8:0] accel_y;
    logic [3:0] btn;
    logic       enable;
    logic [3:0] movement;
    logic [1:0] tilt_active;

    int         tests = 0;
    int         fails = 0;
    int         n;
    logic [3:0] seen;

    tilt_move_ctrl #(.TICK_DIV(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .accel_x    (accel_x),
        .accel_y    (accel_y),
        .btn        (btn),
        .enable     (enable),
        .movement   (movement),
        .tilt_active(tilt_active)
    );

    always #5 clk = ~clk;

    // Advance clock edges until movement goes nonzero or the limit expires.
    task automatic wait_move(input int limit, output int cnt, output logic [3:0] mv);
        mv  = '0;
        cnt = 0;
        while (cnt < limit && mv == 4'b0000) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
            mv = movement;
        end
    endtask

    task automatic center();
        accel_x = 9'd256;
        accel_y = 9'd256;
        btn     = 4'b0000;
        enable  = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset();
        accel_x = 9'd511;
        accel_y = 9'd0;
        btn     = 4'b1111;
        enable  = 1'b1;
        reset   = 1'b1;
        #2 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (movement !== 4'b0000 || tilt_active !== 2'b00) begin
                fails++;
                $display("FAIL reset_hold: movement=%b tilt_active=%b, want 0000/00", movement, tilt_active);
            end
        end
        accel_x = 9'd256;
        accel_y = 9'd256;
        btn     = 4'b0000;
        reset   = 1'b1;
        wait_move(5000, n, seen);
        tests++;
        if (seen !== 4'b0000) begin
            fails++;
            $display("FAIL idle_centre: movement=%b after %0d cycles, want none in 5000", seen, n);
        end
    endtask

    task automatic test_tilt_period();
        center();
        accel_x = 9'd356;
        wait_move(1700, n, seen);
        tests++;
        if (seen !== 4'b1000 || n < 1544 || n > 1553) begin
            fails++;
            $display("FAIL tilt_first: movement=%b at %0d, want 1000 in 1544..1553", seen, n);
        end
        tests++;
        if (tilt_active !== 2'b01) begin
            fails++;
            $display("FAIL tilt_active_x: got %b, want 01", tilt_active);
        end
        wait_move(1700, n, seen);
        tests++;
        if (seen !== 4'b1000 || n != 1550) begin
            fails++;
            $display("FAIL tilt_interval: movement=%b after %0d, want 1000 after 1550", seen, n);
        end
    endtask

    task automatic test_clamp();
        center();
        accel_x = 9'd511;
        wait_move(200, n, seen);
        tests++;
        if (seen !== 4'b1000 || n < 74 || n > 83) begin
            fails++;
            $display("FAIL clamp_right_first: movement=%b at %0d, want 1000 in 74..83", seen, n);
        end
        wait_move(200, n, seen);
        tests++;
        if (seen !== 4'b1000 || n != 80) begin
            fails++;
            $display("FAIL clamp_right_interval: movement=%b after %0d, want 1000 after 80", seen, n);
        end
        center();
        accel_x = 9'd0;
        wait_move(200, n, seen);
        tests++;
        if (seen !== 4'b0100 || n < 74 || n > 83) begin
            fails++;
            $display("FAIL clamp_left_first: movement=%b at %0d, want 0100 in 74..83", seen, n);
        end
        wait_move(200, n, seen);
        tests++;
        if (seen !== 4'b0100 || n != 80) begin
            fails++;
            $display("FAIL clamp_left_interval: movement=%b after %0d, want 0100 after 80", seen, n);
        end
    endtask

    task automatic test_deadzone();
        center();
        accel_x = 9'd270;
        repeat (30) @(negedge clk);
        tests++;
        if (tilt_active !== 2'b00) begin
            fails++;
            $display("FAIL deadzone_active: got %b, want 00", tilt_active);
        end
        wait_move(2500, n, seen);
        tests++;
        if (seen !== 4'b0000) begin
            fails++;
            $display("FAIL deadzone_pulse: movement=%b at %0d, want none", seen, n);
        end
        accel_x = 9'd272;
        accel_y = 9'd241;
        repeat (5) @(negedge clk);
        tests++;
        if (tilt_active !== 2'b01) begin
            fails++;
            $display("FAIL deadzone_edge: got %b, want 01", tilt_active);
        end
    endtask

    task automatic test_dir_change();
        center();
        accel_x = 9'd356;
        wait_move(1000, n, seen);
        tests++;
        if (seen !== 4'b0000) begin
            fails++;
            $display("FAIL dir_pre: movement=%b at %0d, want none", seen, n);
        end
        accel_x = 9'd156;
        wait_move(1700, n, seen);
        tests++;
        if (seen !== 4'b0100 || n < 1544 || n > 1553) begin
            fails++;
            $display("FAIL dir_change: movement=%b at %0d, want 0100 in 1544..1553", seen, n);
        end
    endtask

    task automatic test_diagonal();
        center();
        accel_x = 9'd356;
        accel_y = 9'd156;
        wait_move(1700, n, seen);
        tests++;
        if (seen !== 4'b1001 || n < 1544 || n > 1553) begin
            fails++;
            $display("FAIL diag_first: movement=%b at %0d, want 1001 in 1544..1553", seen, n);
        end
        tests++;
        if (tilt_active !== 2'b11) begin
            fails++;
            $display("FAIL diag_active: got %b, want 11", tilt_active);
        end
        wait_move(1700, n, seen);
        tests++;
        if (seen !== 4'b1001 || n != 1550) begin
            fails++;
            $display("FAIL diag_interval: movement=%b after %0d, want 1001 after 1550", seen, n);
        end
    endtask

    task automatic test_enable();
        center();
        enable  = 1'b0;
        accel_x = 9'd511;
        wait_move(300, n, seen);
        tests++;
        if (seen !== 4'b0000) begin
            fails++;
            $display("FAIL enable_off: movement=%b at %0d, want none", seen, n);
        end
        enable = 1'b1;
        wait_move(200, n, seen);
        tests++;
        if (seen !== 4'b1000 || n < 71 || n > 80) begin
            fails++;
            $display("FAIL enable_on: movement=%b at %0d, want 1000 in 71..80", seen, n);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (movement !== 4'b0000 || tilt_active !== 2'b00) begin
                fails++;
                $display("FAIL reset_mid_hold: movement=%b tilt_active=%b, want 0000/00", movement, tilt_active);
            end
        end
        reset = 1'b1;
        wait_move(200, n, seen);
        tests++;
        if (seen !== 4'b1000 || n != 80) begin
            fails++;
            $display("FAIL reset_mid_first: movement=%b at %0d, want 1000 at 80", seen, n);
        end
    endtask

`ifdef TILT_BUTTON_OVERRIDE_EN
    task automatic test_button();
        center();
        accel_x = 9'd356;
        btn     = 4'b0001;
        wait_move(1100, n, seen);
        tests++;
        if (seen !== 4'b0001 || n < 993 || n > 1002) begin
            fails++;
            $display("FAIL btn_first: movement=%b at %0d, want 0001 in 993..1002", seen, n);
        end
        wait_move(1100, n, seen);
        tests++;
        if (seen !== 4'b0001 || n != 1000) begin
            fails++;
            $display("FAIL btn_interval: movement=%b after %0d, want 0001 after 1000", seen, n);
        end
        btn = 4'b0000;
        wait_move(1700, n, seen);
        tests++;
        if (seen !== 4'b1000 || n < 1543 || n > 1552) begin
            fails++;
            $display("FAIL btn_release: movement=%b at %0d, want 1000 in 1543..1552", seen, n);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_tilt_period();
        test_clamp();
        test_deadzone();
        test_dir_change();
        test_diagonal();
        test_enable();
        test_reset_mid();
`ifdef TILT_BUTTON_OVERRIDE_EN
        test_button();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
